mem_stage: RTL

//  MEM pipeline stage: owns the EX->MEM pipeline register and finishes loads by waiting for data-SRAM read return.

---
 rtl/mem_stage_pkg.sv | 62 ++++++
 rtl/mem_stage_if.sv | 24 ++
 rtl/mem_load_ext.sv | 30 +++
 rtl/mem_stage.sv | 139 +++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
// Optional feature macro: MEM_HILO_EN adds HI/LO pass-through fields to both stage buses.
package mem_stage_pkg;

    localparam int   STALL_W       = 7;
    localparam int   STALL_MEM_IN  = 5;
    localparam int   STALL_MEM_OUT = 6;
    localparam logic STOP          = 1'b1;
    localparam logic NO_STOP       = 1'b0;

    typedef enum logic [2:0] {
        LOAD_NONE = 3'd0,
        LOAD_LB   = 3'd1,
        LOAD_LBU  = 3'd2,
        LOAD_LH   = 3'd3,
        LOAD_LHU  = 3'd4,
        LOAD_LW   = 3'd5
    } load_op_e;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_HOLD = 2'd2
    } mem_state_e;

    // load_op stays a plain 3-bit field so the unused codes 6/7 can travel through
    typedef struct packed {
`ifdef MEM_HILO_EN
        logic        hi_we;
        logic        lo_we;
        logic [31:0] hi;
        logic [31:0] lo;
`endif
        logic [31:0] pc;
        logic [2:0]  load_op;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_to_mem_t;

    typedef struct packed {
`ifdef MEM_HILO_EN
        logic        hi_we;
        logic        lo_we;
        logic [31:0] hi;
        logic [31:0] lo;
`endif
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } mem_to_wb_t;

    localparam int EX_TO_MEM_WD = $bits(ex_to_mem_t);
    localparam int MEM_TO_WB_WD = $bits(mem_to_wb_t);

    // Codes 6 and 7 are not loads
    function automatic logic is_load(input logic [2:0] op);
        return (op >= LOAD_LB) && (op <= LOAD_LW);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Bus bundle between the pipeline/memory system and the MEM stage.
// Optional feature macro: MEM_HILO_EN (widens both stage buses through the package types).
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic                    flush;
    logic [STALL_W-1:0]      stall;
    logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
    logic                    data_rvalid;
    logic [31:0]             data_rdata;
    logic                    stallreq_mem;
    logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;

    modport master (
        output flush, stall, ex_to_mem_bus, data_rvalid, data_rdata,
        input  stallreq_mem, mem_to_wb_bus
    );

    modport slave (
        input  flush, stall, ex_to_mem_bus, data_rvalid, data_rdata,
        output stallreq_mem, mem_to_wb_bus
    );

endinterface

// File: rtl/mem_load_ext.sv
// Load data lane selection and sign/zero extension for the MEM stage.
// Optional feature macro: MEM_HILO_EN (not used here).
module mem_load_ext
    import mem_stage_pkg::*;
(
    input  logic [2:0]  load_op,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] wdata
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Pick the addressed byte/half lane and widen it to a register value
    always_comb begin
        byte_lane = rdata[{addr, 3'b000} +: 8];
        half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
        wdata     = '0;
        case (load_op)
            LOAD_LB:  wdata = {{24{byte_lane[7]}}, byte_lane};
            LOAD_LBU: wdata = {24'd0, byte_lane};
            LOAD_LH:  wdata = {{16{half_lane[15]}}, half_lane};
            LOAD_LHU: wdata = {16'd0, half_lane};
            LOAD_LW:  wdata = rdata;
            default:  wdata = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX->MEM register, load-return FSM, killed-load drop counter,
// return buffer for held output, and MEM->WB bus packing.
// Optional feature macro: MEM_HILO_EN passes HI/LO write fields straight through.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    mem_stage_if.slave mem_bus
);

    ex_to_mem_t  ex_in, ex_d, ex_q;
    mem_state_e  state_d, state_q;
    logic [1:0]  drop_cnt_d, drop_cnt_q;
    logic [31:0] rdata_buf_d, rdata_buf_q;

    logic        stop_in, stop_out, capture, new_load;
    logic        ret_ok, ret_drop, kill_pending, stallreq;
    logic [31:0] load_data, ext_data, rf_wdata;
    mem_to_wb_t  wb_out;
    logic        unused_stall_bits;

    assign ex_in     = ex_to_mem_t'(mem_bus.ex_to_mem_bus);
    assign stop_in   = (mem_bus.stall[STALL_MEM_IN] == STOP);
    assign stop_out  = (mem_bus.stall[STALL_MEM_OUT] == STOP);
    assign capture   = !mem_bus.flush && !stop_in;
    assign new_load  = capture && is_load(ex_in.load_op);
    assign ret_ok    = mem_bus.data_rvalid && (drop_cnt_q == 2'd0);
    assign ret_drop  = mem_bus.data_rvalid && (drop_cnt_q != 2'd0);
    assign unused_stall_bits = ^{mem_bus.stall[STALL_MEM_IN-1:0]};

    // Next value of the EX->MEM register: flush and front-only stall insert a bubble
    always_comb begin
        ex_d = ex_q;
        if (mem_bus.flush) begin
            ex_d = '0;
        end else if (stop_in && !stop_out) begin
            ex_d = '0;
        end else if (!stop_in) begin
            ex_d = ex_in;
        end
    end

    // Load-return FSM plus the count of returns still owed to killed loads
    always_comb begin
        state_d      = state_q;
        rdata_buf_d  = rdata_buf_q;
        drop_cnt_d   = drop_cnt_q;
        kill_pending = 1'b0;
        stallreq     = 1'b0;
        unique case (state_q)
            MEM_IDLE: begin
                if (new_load) begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                stallreq = !ret_ok;
                if (mem_bus.flush) begin
                    state_d      = MEM_IDLE;
                    kill_pending = !ret_ok;
                end else if (ret_ok) begin
                    if (stop_out) begin
                        rdata_buf_d = mem_bus.data_rdata;
                        state_d     = MEM_HOLD;
                    end else begin
                        state_d = new_load ? MEM_WAIT : MEM_IDLE;
                    end
                end
            end
            MEM_HOLD: begin
                if (mem_bus.flush) begin
                    rdata_buf_d = '0;
                    state_d     = MEM_IDLE;
                end else if (!stop_out) begin
                    state_d = new_load ? MEM_WAIT : MEM_IDLE;
                end
            end
            default: begin
                state_d = MEM_IDLE;
            end
        endcase
        if (kill_pending && !ret_drop) begin
            if (drop_cnt_q != 2'd3) begin
                drop_cnt_d = drop_cnt_q + 2'd1;
            end
        end else if (ret_drop && !kill_pending) begin
            drop_cnt_d = drop_cnt_q - 2'd1;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_q        <= '0;
            state_q     <= MEM_IDLE;
            drop_cnt_q  <= 2'd0;
            rdata_buf_q <= '0;
        end else begin
            ex_q        <= ex_d;
            state_q     <= state_d;
            drop_cnt_q  <= drop_cnt_d;
            rdata_buf_q <= rdata_buf_d;
        end
    end

    assign load_data = (state_q == MEM_HOLD) ? rdata_buf_q : mem_bus.data_rdata;

    mem_load_ext u_load_ext (
        .load_op (ex_q.load_op),
        .addr    (ex_q.ex_result[1:0]),
        .rdata   (load_data),
        .wdata   (ext_data)
    );

    // Pack the write-back bus; non-loads forward the EX result
    always_comb begin
        rf_wdata        = is_load(ex_q.load_op) ? ext_data : ex_q.ex_result;
        wb_out          = '0;
`ifdef MEM_HILO_EN
        wb_out.hi_we    = ex_q.hi_we;
        wb_out.lo_we    = ex_q.lo_we;
        wb_out.hi       = ex_q.hi;
        wb_out.lo       = ex_q.lo;
`endif
        wb_out.pc       = ex_q.pc;
        wb_out.rf_we    = ex_q.rf_we;
        wb_out.rf_waddr = ex_q.rf_waddr;
        wb_out.rf_wdata = rf_wdata;
    end

    assign mem_bus.mem_to_wb_bus = wb_out;
    assign mem_bus.stallreq_mem  = stallreq;

    // A return with no load waiting and nothing left to drop breaks the bus protocol
    a_no_stray_return: assert property (@(posedge clk) disable iff (!rst)
        !(mem_bus.data_rvalid && (state_q != MEM_WAIT) && (drop_cnt_q == 2'd0)));

endmodule
